// File: rtl/dense2_argmax_sequencer.sv
// Sequencer for the 128->10 dense layer: kicks it, waits for done, streams the logits back and reduces them to a signed argmax.
// Optional macro SCORE_BUF_EN adds a readable buffer holding every captured logit.
module dense2_argmax_sequencer #(
    parameter int NUM_CLASSES    = 10,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     req,
    output logic                     busy,
    output logic                     result_valid,
    output logic [3:0]               class_idx,
    output logic signed [DATA_W-1:0] max_score,
    output logic                     timeout_err,
    output logic                     dl_start,
    input  logic                     dl_done,
    output logic [3:0]               dl_read_addr,
    input  logic signed [DATA_W-1:0] dl_read_data,
`ifdef SCORE_BUF_EN
    input  logic [3:0]               score_rd_addr,
    output logic [DATA_W-1:0]        score_rd_data,
`endif
    output logic [2:0]               dbg_state
);

    // Handshake: req is a level sampled only in IDLE and never in the result_valid
    // cycle; result_valid is a one-cycle pulse with no back-pressure.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_KICK  = 3'd1,
        S_WAIT  = 3'd2,
        S_FETCH = 3'd3,
        S_FINAL = 3'd4
    } state_t;

    localparam logic [3:0]  LAST_ADDR = 4'(NUM_CLASSES - 1);
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    state_t                     state, state_nxt;
    logic [15:0]                wait_cnt;
    logic                       cap_en;
    logic [3:0]                 cap_idx;
    logic signed [DATA_W-1:0]   run_max, cand_max;
    logic [3:0]                 run_idx, cand_idx;
    logic                       done_ok, timed_out;

    assign busy      = (state != S_IDLE);
    assign dl_start  = (state == S_KICK);
    assign dbg_state = state;

    // A done seen in the first WAIT cycle may be stale from the previous run.
    assign done_ok   = (state == S_WAIT) && dl_done && (wait_cnt != 16'd0);
    assign timed_out = (state == S_WAIT) && !done_ok && (wait_cnt == TO_LAST);

    always_comb begin
        cand_max = run_max;
        cand_idx = run_idx;
        if (cap_idx == 4'd0 || dl_read_data > run_max) begin
            cand_max = dl_read_data;
            cand_idx = cap_idx;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (req && !result_valid) state_nxt = S_KICK;
            S_KICK:  state_nxt = S_WAIT;
            S_WAIT: begin
                if (done_ok)        state_nxt = S_FETCH;
                else if (timed_out) state_nxt = S_IDLE;
            end
            S_FETCH: if (dl_read_addr == LAST_ADDR) state_nxt = S_FINAL;
            S_FINAL: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state        <= S_IDLE;
            wait_cnt     <= 16'd0;
            dl_read_addr <= 4'd0;
            cap_en       <= 1'b0;
            cap_idx      <= 4'd0;
            run_max      <= '0;
            run_idx      <= 4'd0;
            result_valid <= 1'b0;
            class_idx    <= 4'd0;
            max_score    <= '0;
            timeout_err  <= 1'b0;
        end else begin
            state        <= state_nxt;
            result_valid <= 1'b0;
            cap_en       <= (state == S_FETCH);
            cap_idx      <= dl_read_addr;

            if (state == S_IDLE && state_nxt == S_KICK) timeout_err <= 1'b0;

            if (state == S_KICK)      wait_cnt <= 16'd0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + 16'd1;

            if (state == S_FETCH && dl_read_addr != LAST_ADDR) dl_read_addr <= dl_read_addr + 4'd1;
            else                                               dl_read_addr <= 4'd0;

            if (cap_en) begin
                run_max <= cand_max;
                run_idx <= cand_idx;
            end

            if (timed_out) begin
                timeout_err  <= 1'b1;
                class_idx    <= 4'hF;
                max_score    <= '0;
                result_valid <= 1'b1;
            end

            // The final logit arrives in FINAL, so publish the candidate, not run_max.
            if (state == S_FINAL) begin
                class_idx    <= cand_idx;
                max_score    <= cand_max;
                result_valid <= 1'b1;
            end
        end
    end

`ifdef SCORE_BUF_EN
    logic [DATA_W-1:0] score_mem [NUM_CLASSES];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < NUM_CLASSES; i++) score_mem[i] <= '0;
            score_rd_data <= '0;
        end else begin
            if (cap_en) score_mem[cap_idx] <= dl_read_data;
            if ({1'b0, score_rd_addr} < 5'(NUM_CLASSES)) score_rd_data <= score_mem[score_rd_addr];
            else                                         score_rd_data <= '0;
        end
    end
`endif

endmodule
